// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: EX/MEM inputs, data-bus handshake and MEM/WB outputs of the LSU.
interface mem_stage_lsu_if;
  logic        rd_en;
  logic        wr_en;
  logic        reg_wr;
  logic [1:0]  sel_dm;
  logic [31:0] alu_out;
  logic [31:0] rdata2;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        stall;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        wb_reg_wr;
  logic [1:0]  wb_sel_dm;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_load_data;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        misalign_err;
  logic        bus_err;
  modport master (
    output rd_en, wr_en, reg_wr, sel_dm, alu_out, rdata2, pc, inst, dbus_ack, dbus_rdata,
    input  stall, dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
           wb_reg_wr, wb_sel_dm, wb_alu_out, wb_load_data, wb_pc, wb_inst, misalign_err, bus_err
  );
  modport slave (
    input  rd_en, wr_en, reg_wr, sel_dm, alu_out, rdata2, pc, inst, dbus_ack, dbus_rdata,
    output stall, dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
           wb_reg_wr, wb_sel_dm, wb_alu_out, wb_load_data, wb_pc, wb_inst, misalign_err, bus_err
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit; req/ack data bus, upstream stall, MEM/WB register.
module mem_stage_lsu #(
  parameter int MAX_WAIT = 16
) (
  input logic            clk,
  input logic            reset,
  mem_stage_lsu_if.slave lsu_io
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic        reg_wr;
    logic [1:0]  sel_dm;
    logic [31:0] alu_out;
    logic [31:0] pc;
    logic [31:0] inst;
  } wb_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  wb_t           lat_q, wb_q, in_wb;
  logic [31:0]   load_q, addr_q, wdata_q, wdata_d, load_d;
  logic [3:0]    wstrb_q, strb_d;
  logic          we_q, byte_q, half_q, uns_q, misal_q, bus_err_q;
  logic [2:0]    f3;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          mem_op, is_ld, byte_acc, half_acc, misal, start, busy, tmo;
  // A load+store request is a store; unknown funct3 codes fall back to word size.
  always_comb begin
    f3       = lsu_io.inst[14:12];
    mem_op   = lsu_io.rd_en | lsu_io.wr_en;
    is_ld    = lsu_io.rd_en & ~lsu_io.wr_en;
    byte_acc = f3 == 3'b000 || (is_ld && f3 == 3'b100);
    half_acc = f3 == 3'b001 || (is_ld && f3 == 3'b101);
    misal    = half_acc ? lsu_io.alu_out[0] : !byte_acc && lsu_io.alu_out[1:0] != 2'b00;
    busy     = state_q == BUSY;
    start    = !busy && mem_op && !misal;
    tmo      = busy && !lsu_io.dbus_ack && cnt_q == CW'(MAX_WAIT - 1);
    in_wb    = '{reg_wr: lsu_io.reg_wr, sel_dm: lsu_io.sel_dm, alu_out: lsu_io.alu_out,
                 pc: lsu_io.pc, inst: lsu_io.inst};
    wdata_d  = byte_acc ? {4{lsu_io.rdata2[7:0]}} : half_acc ? {2{lsu_io.rdata2[15:0]}} : lsu_io.rdata2;
    strb_d   = byte_acc ? 4'b0001 << lsu_io.alu_out[1:0] :
               half_acc ? (lsu_io.alu_out[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    byte_v   = 8'(lsu_io.dbus_rdata >> {addr_q[1:0], 3'b000});
    half_v   = 16'(lsu_io.dbus_rdata >> {addr_q[1], 4'b0000});
    load_d   = we_q ? 32'h0 :
               byte_q ? {{24{~uns_q & byte_v[7]}}, byte_v} :
               half_q ? {{16{~uns_q & half_v[15]}}, half_v} : lsu_io.dbus_rdata;
  end
  assign lsu_io.stall        = !reset && (start || (busy && !lsu_io.dbus_ack && !tmo));
  assign lsu_io.dbus_req     = busy;
  assign lsu_io.dbus_we      = we_q;
  assign lsu_io.dbus_addr    = {addr_q[31:2], 2'b00};
  assign lsu_io.dbus_wdata   = wdata_q;
  assign lsu_io.dbus_wstrb   = wstrb_q;
  assign lsu_io.wb_reg_wr    = wb_q.reg_wr;
  assign lsu_io.wb_sel_dm    = wb_q.sel_dm;
  assign lsu_io.wb_alu_out   = wb_q.alu_out;
  assign lsu_io.wb_pc        = wb_q.pc;
  assign lsu_io.wb_inst      = wb_q.inst;
  assign lsu_io.wb_load_data = load_q;
  assign lsu_io.misalign_err = misal_q;
  assign lsu_io.bus_err      = bus_err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_q     <= '0;
      wb_q      <= '0;
      load_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      half_q    <= 1'b0;
      uns_q     <= 1'b0;
      misal_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      misal_q   <= 1'b0;
      bus_err_q <= 1'b0;
      load_q    <= '0;
      if (!busy) begin
        wb_q        <= start ? wb_t'('0) : in_wb;
        wb_q.reg_wr <= lsu_io.reg_wr & ~mem_op;
        misal_q     <= mem_op & misal;
        if (start) begin
          state_q <= BUSY;
          cnt_q   <= '0;
          lat_q   <= in_wb;
          addr_q  <= lsu_io.alu_out;
          we_q    <= !is_ld;
          wdata_q <= wdata_d;
          wstrb_q <= is_ld ? 4'b0000 : strb_d;
          byte_q  <= byte_acc;
          half_q  <= half_acc;
          uns_q   <= f3[2];
        end
      end else if (lsu_io.dbus_ack) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        wb_q    <= lat_q;
        load_q  <= load_d;
      end else begin
        wb_q  <= '0;
        cnt_q <= cnt_q + 1'b1;
        if (tmo) begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          bus_err_q <= 1'b1;
        end
      end
    end
  end
endmodule
